// File: rtl/snake_frame_renderer.sv
// Maps a grid cell to RGB for PLAY / DEATH_FLASH / OVER ("GAME OVER" fade screen).
// 3-cycle latency, 1 pixel per cycle, no backpressure (the pipeline never stalls).
module snake_frame_renderer #(
  parameter int GRID_W       = 100,
  parameter int GRID_H       = 75,
  parameter int MAX_LEN      = 64,
  parameter int POS_BITS     = 13,
  parameter int COLOR_BITS   = 4,
  parameter int FLASH_FRAMES = 30,
  parameter int FADE_DIV     = 8,
  localparam int LEN_BITS    = $clog2(MAX_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         pix_valid_in,
  input  logic [10:0]                  XCoord,
  input  logic [10:0]                  YCoord,
  input  logic [POS_BITS*MAX_LEN-1:0]  snake_body_flat,
  input  logic [LEN_BITS-1:0]          snake_length,
  input  logic [POS_BITS-1:0]          food_pos,
  input  logic                         game_over,
  input  logic                         pause,
  output logic                         pix_valid_out,
  output logic [COLOR_BITS-1:0]        pixel_red,
  output logic [COLOR_BITS-1:0]        pixel_green,
  output logic [COLOR_BITS-1:0]        pixel_blue
);

  localparam int X0    = (GRID_W - 72) / 2;
  localparam int Y0    = (GRID_H - 8) / 2;
  localparam int CNT_MAX = (FLASH_FRAMES > FADE_DIV) ? FLASH_FRAMES : FADE_DIV;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [10:0] GW_C  = 11'(GRID_W);
  localparam logic [10:0] GH_C  = 11'(GRID_H);
  localparam logic [10:0] FX0_C = 11'(X0);
  localparam logic [10:0] FY0_C = 11'(Y0);
  localparam logic [10:0] FX1_C = 11'(X0 + 72);
  localparam logic [10:0] FY1_C = 11'(Y0 + 8);
  localparam logic [COLOR_BITS-1:0] F = '1;

  typedef enum logic [1:0] {ST_PLAY, ST_FLASH, ST_OVER} state_e;

  // ---------------- frame state machine ----------------
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [COLOR_BITS-1:0]   fade_q, fade_d;
  logic                    phase_q, phase_d;
  logic                    go_q;
  logic                    mode_play, mode_flash, mode_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      frame_cnt_q <= '0;
      fade_q      <= '0;
      phase_q     <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      fade_q      <= fade_d;
      phase_q     <= phase_d;
      go_q        <= game_over;
    end
  end

  // flash_phase restarts at 0 on entry so the first flash frame is red
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    fade_d      = fade_q;
    phase_d     = phase_q;
    if (!game_over) begin
      state_d     = ST_PLAY;
      frame_cnt_d = '0;
      fade_d      = '0;
      phase_d     = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (!go_q) begin
            state_d     = ST_FLASH;
            frame_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end
        ST_FLASH: begin
          if (frame_start) begin
            phase_d = ~phase_q;
            if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
              state_d     = ST_OVER;
              frame_cnt_d = '0;
              fade_d      = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (frame_start) begin
            if (frame_cnt_q == CNT_W'(FADE_DIV - 1)) begin
              frame_cnt_d = '0;
              fade_d      = fade_q + 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    mode_play  = (state_q == ST_PLAY);
    mode_flash = (state_q == ST_FLASH);
    mode_over  = (state_q == ST_OVER);
  end

  // ---------------- S0: coordinates, in-grid, flat index ----------------
  logic                vld0_q, in_grid0_q;
  logic [10:0]         x0_q, y0_q;
  logic [POS_BITS-1:0] pos0_q;
  logic                in_grid_d;
  logic [POS_BITS-1:0] pos_d;
  logic [31:0]         pos_full;

  always_comb begin
    in_grid_d = (XCoord < GW_C) && (YCoord < GH_C);
    pos_full  = 32'(YCoord) * 32'(GRID_W) + 32'(XCoord);
    pos_d     = in_grid_d ? POS_BITS'(pos_full) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q     <= 1'b0;
      in_grid0_q <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      pos0_q     <= '0;
    end else begin
      vld0_q     <= pix_valid_in;
      in_grid0_q <= in_grid_d;
      x0_q       <= XCoord;
      y0_q       <= YCoord;
      pos0_q     <= pos_d;
    end
  end

  // ---------------- S1: hit flags and font indices ----------------
  logic                vld1_q, in_grid1_q, head1_q, body1_q, food1_q, font_in1_q;
  logic [3:0]          char1_q;
  logic [2:0]          row1_q, col1_q;
  logic [LEN_BITS-1:0] eff_len;
  logic                head_d, body_d, food_d, font_in_d;
  logic [3:0]          char_d;
  logic [2:0]          row_d, col_d;

  always_comb begin
    eff_len = (snake_length > LEN_BITS'(MAX_LEN)) ? LEN_BITS'(MAX_LEN) : snake_length;
    head_d  = in_grid0_q && (eff_len != '0) &&
              (snake_body_flat[POS_BITS-1:0] == pos0_q);
    body_d  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_BITS'(i) < eff_len) &&
          (snake_body_flat[i*POS_BITS +: POS_BITS] == pos0_q))
        body_d = 1'b1;
    end
    body_d    = body_d && in_grid0_q;
    food_d    = in_grid0_q && (food_pos == pos0_q);
    font_in_d = in_grid0_q && (x0_q >= FX0_C) && (x0_q < FX1_C) &&
                (y0_q >= FY0_C) && (y0_q < FY1_C);
    char_d    = 4'((x0_q - FX0_C) >> 3);
    col_d     = 3'(x0_q - FX0_C);
    row_d     = 3'(y0_q - FY0_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q     <= 1'b0;
      in_grid1_q <= 1'b0;
      head1_q    <= 1'b0;
      body1_q    <= 1'b0;
      food1_q    <= 1'b0;
      font_in1_q <= 1'b0;
      char1_q    <= '0;
      row1_q     <= '0;
      col1_q     <= '0;
    end else begin
      vld1_q     <= vld0_q;
      in_grid1_q <= in_grid0_q;
      head1_q    <= head_d;
      body1_q    <= body_d;
      food1_q    <= food_d;
      font_in1_q <= font_in_d;
      char1_q    <= char_d;
      row1_q     <= row_d;
      col1_q     <= col_d;
    end
  end

  // ---------------- S2: font lookup and final colour ----------------
  // Glyph rows top to bottom, MSB = leftmost pixel; message "GAME OVER"
  function automatic logic [63:0] font_rom(input logic [3:0] char_idx);
    case (char_idx)
      4'd0:    font_rom = 64'h3C66C0C0CE663E00;
      4'd1:    font_rom = 64'h183C66667E666600;
      4'd2:    font_rom = 64'hC6EEFED6C6C6C600;
      4'd3:    font_rom = 64'h7E60607C60607E00;
      4'd5:    font_rom = 64'h3C66666666663C00;
      4'd6:    font_rom = 64'h66666666663C1800;
      4'd7:    font_rom = 64'h7E60607C60607E00;
      4'd8:    font_rom = 64'h7C66667C6C666600;
      default: font_rom = 64'h0;
    endcase
  endfunction

  logic [63:0]           glyph;
  logic                  font_bit;
  logic [COLOR_BITS-1:0] r_d, g_d, b_d;
  logic                  vld2_q;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;

  always_comb begin
    glyph    = font_rom(char1_q);
    font_bit = glyph[{~row1_q, ~col1_q}];
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vld1_q && in_grid1_q) begin
      if (mode_play) begin
        if (head1_q) begin
          r_d = F;
          g_d = F;
        end else if (body1_q) begin
          g_d = F;
        end else if (food1_q) begin
          r_d = F;
        end
        if (pause) begin
          r_d = r_d >> 1;
          g_d = g_d >> 1;
          b_d = b_d >> 1;
        end
      end else if (mode_flash) begin
        if (head1_q || body1_q) begin
          if (phase_q) g_d = F;
          else         r_d = F;
        end
      end else if (mode_over) begin
        if (font_in1_q && font_bit) begin
          r_d = fade_q;
          g_d = fade_q;
          b_d = fade_q;
        end else begin
          r_d = ~fade_q;
          g_d = ~fade_q;
          b_d = ~fade_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_q <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      vld2_q <= vld1_q;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign pix_valid_out = vld2_q;
  assign pixel_red     = r_q;
  assign pixel_green   = g_q;
  assign pixel_blue    = b_q;

endmodule

// File: tb/tb_snake_frame_renderer.sv
// Randomised bench for snake_frame_renderer against a frame-level behavioural model.
module tb_snake_frame_renderer;
  localparam int GW = 100;
  localparam int GH = 75;
  localparam int ML = 64;
  localparam int PB = 13;

  logic              clk = 1'b0;
  logic              rst, frame_start, pix_valid_in, game_over, pause;
  logic [10:0]       XCoord, YCoord;
  logic [PB*ML-1:0]  snake_body_flat;
  logic [6:0]        snake_length;
  logic [PB-1:0]     food_pos;
  logic              pix_valid_out;
  logic [3:0]        pixel_red, pixel_green, pixel_blue;

  snake_frame_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .XCoord(XCoord), .YCoord(YCoord), .snake_body_flat(snake_body_flat),
    .snake_length(snake_length), .food_pos(food_pos), .game_over(game_over),
    .pause(pause), .pix_valid_out(pix_valid_out), .pixel_red(pixel_red),
    .pixel_green(pixel_green), .pixel_blue(pixel_blue)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // snake / food configuration as plain integers
  int seg [ML];
  int slen;
  int food;

  // game progress: mode 0 = play, 1 = death flash, 2 = game over
  int mode, flashes, overs, go_prev;
  int p_vld [2];
  int p_x [2];
  int p_y [2];
  logic [12:0] exp_px, obs;

  logic [63:0] glyphs [9] = '{64'h3C66C0C0CE663E00, 64'h183C66667E666600,
                              64'hC6EEFED6C6C6C600, 64'h7E60607C60607E00,
                              64'h0, 64'h3C66666666663C00, 64'h66666666663C1800,
                              64'h7E60607C60607E00, 64'h7C66667C6C666600};

  function automatic logic [12:0] colour(input int v, input int x, input int y);
    logic [3:0] r, g, b, fade;
    int pos, le, ch, col, row;
    bit hd, bd, fd;
    logic [63:0] gl;
    r = 0; g = 0; b = 0; hd = 0; bd = 0;
    if (v == 0) return 13'd0;
    if (x >= GW || y >= GH) return 13'h1000;
    pos = y * GW + x;
    le = (slen > ML) ? ML : slen;
    for (int i = 0; i < le; i++)
      if (seg[i] == pos) begin
        if (i == 0) hd = 1; else bd = 1;
      end
    fd = (food == pos);
    if (mode == 0) begin
      if (hd) begin r = 15; g = 15; end
      else if (bd) g = 15;
      else if (fd) r = 15;
      if (pause) begin r = r / 2; g = g / 2; b = b / 2; end
    end else if (mode == 1) begin
      if (hd || bd) begin
        if (flashes % 2 == 1) g = 15; else r = 15;
      end
    end else begin
      fade = 4'((overs / 8) % 16);
      r = 4'(15 - fade); g = r; b = r;
      if (x >= 14 && x < 86 && y >= 33 && y < 41) begin
        ch = (x - 14) / 8; col = (x - 14) % 8; row = y - 33;
        gl = glyphs[ch];
        if (gl[63 - row * 8 - col]) begin r = fade; g = fade; b = fade; end
      end
    end
    return {1'b1, r, g, b};
  endfunction

  task automatic load_snake();
    for (int i = 0; i < ML; i++) snake_body_flat[i*PB +: PB] = PB'(seg[i]);
    snake_length = 7'(slen);
    food_pos = PB'(food);
  endtask

  // One clock: advance the model at the edge, compare DUT outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      p_vld[0] = 0; p_vld[1] = 0; exp_px = 13'd0;
      mode = 0; flashes = 0; overs = 0; go_prev = 0;
    end else begin
      exp_px = colour(p_vld[1], p_x[1], p_y[1]);
      p_vld[1] = p_vld[0]; p_x[1] = p_x[0]; p_y[1] = p_y[0];
      p_vld[0] = int'(pix_valid_in); p_x[0] = int'(XCoord); p_y[0] = int'(YCoord);
      if (!game_over) begin
        mode = 0; flashes = 0; overs = 0;
      end else if (mode == 0) begin
        if (go_prev == 0) begin mode = 1; flashes = 0; end
      end else if (frame_start) begin
        if (mode == 1) begin
          flashes++;
          if (flashes == 30) begin mode = 2; overs = 0; end
        end else overs++;
      end
      go_prev = int'(game_over);
    end
    @(negedge clk);
    obs = {pix_valid_out, pixel_red, pixel_green, pixel_blue};
    n_vec++;
    if (obs !== exp_px) begin
      n_fail++;
      $display("FAIL model t=%0t: got %h want %h", $time, obs, exp_px);
    end
  endtask

  task automatic lit(input string name, input logic [12:0] want);
    n_vec++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, obs, want);
    end
  endtask

  task automatic pix(input int x, input int y);
    pix_valid_in = 1'b1; XCoord = 11'(x); YCoord = 11'(y);
    tick();
  endtask

  task automatic idle();
    pix_valid_in = 1'b0;
    tick();
  endtask

  task automatic probe(input int x, input int y);
    pix(x, y); idle(); idle();
  endtask

  task automatic pulse();
    pix_valid_in = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rand_pix();
    int k, p;
    if ($urandom_range(0, 3) == 0) begin
      k = $urandom_range(0, ML - 1); p = seg[k];
      pix(p % GW, p / GW);
    end else begin
      pix($urandom_range(0, 110), $urandom_range(0, 85));
    end
  endtask

  task automatic config_a();
    for (int i = 0; i < ML; i++) seg[i] = 0;
    seg[0] = 205; seg[1] = 206; slen = 2; food = 300;
    load_snake();
  endtask

  initial begin
    rst = 1'b1; frame_start = 0; pix_valid_in = 0; game_over = 0; pause = 0;
    XCoord = 0; YCoord = 0;
    mode = 0; flashes = 0; overs = 0; go_prev = 0;
    p_vld[0] = 0; p_vld[1] = 0; p_x[0] = 0; p_x[1] = 0; p_y[0] = 0; p_y[1] = 0;
    config_a();
    tick(); tick();
    lit("reset_out", 13'h0000);
    rst = 1'b0;
    tick();
    lit("after_reset", 13'h0000);

    // basic PLAY colours
    pix(5, 2); pix(6, 2); pix(0, 3);
    lit("head", 13'h1FF0);
    pix(99, 74);
    lit("body", 13'h10F0);
    idle(); lit("food", 13'h1F00);
    idle(); lit("black", 13'h1000);

    // off-grid and length edge cases
    slen = 0; load_snake();
    probe(100, 0); lit("offgrid", 13'h1000);
    probe(5, 2);   lit("len0_nohead", 13'h1000);
    for (int i = 0; i < ML - 1; i++) seg[i] = 2000 + 3 * i;
    seg[ML-1] = 7000; slen = ML + 1; load_snake();
    probe(0, 70);  lit("clamp_last_seg", 13'h10F0);
    slen = ML - 1; load_snake();
    probe(0, 70);  lit("len63_excl", 13'h1000);

    // randomised PLAY traffic
    for (int rnd = 0; rnd < 6; rnd++) begin
      slen = $urandom_range(0, ML + 2);
      for (int i = 0; i < ML; i++) seg[i] = $urandom_range(0, GW * GH - 1);
      food = $urandom_range(0, GW * GH - 1);
      load_snake();
      for (int c = 0; c < 60; c++) begin
        pause = ($urandom_range(0, 4) == 0);
        frame_start = $urandom_range(0, 1);
        if ($urandom_range(0, 3) != 0) rand_pix(); else idle();
      end
      frame_start = 0; pause = 0;
      idle(); idle(); idle();
    end

    config_a();
    pause = 1'b1;
    probe(5, 2); lit("pause_head", 13'h1770);

    // death flash: entry pulse is not counted
    game_over = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    probe(5, 2); lit("flash0_red_nopause", 13'h1F00);
    probe(0, 3); lit("flash_food_hidden", 13'h1000);
    for (int i = 1; i <= 30; i++) begin
      pulse();
      if (i < 30) begin
        probe(5, 2);
        if (i == 1) lit("flash1_green", 13'h10F0);
        if (i == 2) lit("flash2_red", 13'h1F00);
        rand_pix(); pix(6, 2); idle(); idle();
      end
    end
    probe(0, 0); lit("over_bg_k0", 13'h1FFF);

    // game-over fade
    for (int k = 1; k <= 17; k++) begin
      pause = $urandom_range(0, 1);
      for (int f = 0; f < 8; f++) pulse();
      probe(0, 0);
      if (k == 1) lit("over_bg_k1", 13'h1EEE);
      if (k == 16) lit("fade_wrap_bg", 13'h1FFF);
      probe(14, 35);
      if (k == 1) lit("over_txt_k1", 13'h1111);
      if (k == 17) lit("over_txt_k17", 13'h1111);
      probe(14, 33);
      if (k == 1) lit("over_G_gap", 13'h1EEE);
      for (int c = 0; c < 6; c++) pix($urandom_range(8, 95), $urandom_range(30, 44));
      idle(); idle();
    end

    // back to PLAY
    pause = 1'b0; game_over = 1'b0;
    tick();
    probe(5, 2); lit("back_play", 13'h1FF0);

    // reset while pixels are in flight
    pix(5, 2); pix(6, 2);
    rst = 1'b1;
    pix(0, 3);
    lit("rst_mid", 13'h0000);
    rst = 1'b0;
    idle(); lit("rst_release", 13'h0000);
    probe(5, 2); lit("post_rst_head", 13'h1FF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_frame_renderer.md
# snake_frame_renderer

Pipelined, parametrised successor to the game's per-cell pixel renderer. Maps a grid cell coordinate to a COLOR_BITS-per-channel RGB value, with distinct head, body and food colours. A frame-counted state machine sequences PLAY, DEATH_FLASH and OVER, where OVER shows a fading "GAME OVER" screen. Sits between the VGA timing/cell-coordinate generator and the DAC output registers, with a fixed 3-cycle latency tracked by a valid flag.

## Interface
- GRID_W, 100, grid columns
- GRID_H, 75, grid rows
- MAX_LEN, 64, maximum snake segments
- POS_BITS, 13, flat cell index width (≥ clog2(GRID_W*GRID_H))
- COLOR_BITS, 4, bits per colour channel
- FLASH_FRAMES, 30, frames spent in DEATH_FLASH
- FADE_DIV, 8, frames per fade step in OVER

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse per video frame (vsync edge)
- pix_valid_in  in  1  XCoord/YCoord valid this cycle
- XCoord  in  11  cell column
- YCoord  in  11  cell row
- snake_body_flat  in  POS_BITS*MAX_LEN  segment i at [i*POS_BITS +: POS_BITS]; segment 0 = head
- snake_length  in  clog2(MAX_LEN+1)  active segments
- food_pos  in  POS_BITS  flat food index
- game_over  in  1  level from game FSM
- pause  in  1  dim display
- pix_valid_out  out  1  outputs valid
- pixel_red, pixel_green, pixel_blue  out  COLOR_BITS each  colour

## Operation
- Flat index: cur_pos = YCoord*GRID_W + XCoord, truncated to POS_BITS. Compute it only when in-grid.
- Off-grid coordinate (X ≥ GRID_W or Y ≥ GRID_H) → black in every state. It never matches snake or food.
- Effective length = min(snake_length, MAX_LEN). A segment i matches only when i < effective length. Length 0 → no snake drawn.
- PLAY priority: head (F,F,0) > body (0,F,0) > food (F,0,0) > black. F = all-ones COLOR_BITS.
- DEATH_FLASH: snake cells alternate red (F,0,0) and green (0,F,0) per frame. flash_phase toggles on each frame_start. Food is hidden. Background is black.
- OVER: fade = fade_cnt (COLOR_BITS wide); txt = (fade,fade,fade); bg = bitwise inverse of txt. "GAME OVER" is 9 chars × 8×8 font, centred at X0=(GRID_W−72)/2, Y0=(GRID_H−8)/2, using the existing Font_ROM (char_idx 0–8, row_idx, MSB = leftmost pixel). Font bit 1 → txt, otherwise → bg.
- pause (PLAY only): each channel is shifted right by 1. pause is ignored in the other states.
- FSM, state register updates every cycle:
  - PLAY → DEATH_FLASH on a game_over rising edge; frame_cnt is cleared.
  - DEATH_FLASH: frame_cnt increments on frame_start. When frame_cnt = FLASH_FRAMES−1 and frame_start is high → OVER; frame_cnt and fade_cnt are cleared.
  - OVER: frame_cnt counts frame_start modulo FADE_DIV. On wrap, fade_cnt increments and wraps from F to 0.
  - In any state, game_over low → PLAY next cycle; counters are cleared.
- Simultaneous game_over rise and frame_start: enter DEATH_FLASH with frame_cnt = 0. That pulse is not counted.
- Reset: state PLAY; frame_cnt, fade_cnt, flash_phase = 0. All pipeline registers are cleared, so pix_valid_out = 0 and all pixel outputs = 0.

## Timing
- S0 registers coordinates and valid, and computes the in-grid flag and cur_pos.
- S1 registers the hit flags: MAX_LEN parallel comparators reduced to body_hit, plus head_hit, food_hit and font-region/char/row/bit indices.
- S2 registers the final RGB.
- Latency is exactly 3 cycles, input to pix_valid_out/pixel_*. Throughput is 1 pixel/cycle with no stalls.
- With pix_valid_out = 0, pixel outputs are 0.
- State, fade and flash_phase are sampled at S2. A state change takes effect on pixels in S2 from the next cycle onward.
- snake_body_flat, food_pos and snake_length are sampled at S0/S1 and must be held stable for a frame by the game logic.
- Reset mid-stream: the cycle after rst is released, outputs are 0. Valid resumes 3 cycles after the first pix_valid_in.

## Test plan
- Reset, then PLAY: body {head=205, 206}, length 2, food 300. Drive (5,2), (6,2), (0,3), (99,74) → 3 cycles later: (F,F,0), (0,F,0), (F,0,0), black.
- Off-grid and length clamp: (100,0) with snake_length=0 → black. snake_length=MAX_LEN+1 is treated as MAX_LEN; segment MAX_LEN−1 is still drawn.
- pause=1 in PLAY → head reads (7,7,0). Raise game_over → pause has no effect.
- Raise game_over together with frame_start, then issue 30 frame_starts → snake colour alternates red/green each frame. Enter OVER after the 30th. Food is never drawn.
- OVER: after 8·k frame_starts, pixel (0,0) = inverse of (k mod 16). Font pixel at (X0, Y0+…) that is set in 'G' = (k,k,k). fade_cnt wraps F→0.
- Drop game_over while in OVER → the next pixels render in PLAY. Assert rst mid-frame → pix_valid_out and RGB read 0 the next cycle.
